// File: rtl/clb_cfg_pkg.sv
// Shared types and frame-geometry helpers for the CLB configuration loader.
package clb_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } cfg_state_e;

    function automatic int calc_wpl(input int mask_w, input int word_w);
        return mask_w / word_w;
    endfunction

    function automatic int calc_frame_words(input int num_luts, input int mask_w, input int word_w);
        return num_luts * calc_wpl(mask_w, word_w);
    endfunction

endpackage

// File: rtl/clb_cfg_if.sv
// Config-stream handshake and status bundle between a frame source and the loader.
interface clb_cfg_if #(
    parameter int WORD_W = 16
);
    logic              cfg_start;
    logic              cfg_valid;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_ready;
    logic              cfg_busy;
    logic              cfg_done;
    logic              cfg_err;

    modport master (
        output cfg_start, cfg_valid, cfg_data,
        input  cfg_ready, cfg_busy, cfg_done, cfg_err
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data,
        output cfg_ready, cfg_busy, cfg_done, cfg_err
    );
endinterface

// File: rtl/clb_cfg_shadow.sv
// Shadow LUT-mask store with word-indexed writes and a whole-array commit to the active masks.
module clb_cfg_shadow
    import clb_cfg_pkg::*;
#(
    parameter int NUM_LUTS = 10,
    parameter int MASK_W   = 64,
    parameter int WORD_W   = 16,
    parameter int IDX_W    = $clog2(calc_frame_words(NUM_LUTS, MASK_W, WORD_W) + 1)
) (
    input  logic                       C,
    input  logic                       R,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [WORD_W-1:0]          wr_data,
    input  logic                       commit,
    output logic [NUM_LUTS*MASK_W-1:0] lut_mask
);

    logic [NUM_LUTS*MASK_W-1:0] shadow_q;

    // Word n lands at LUT n/WPL, slot n%WPL, which flattens to bit n*WORD_W.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            shadow_q <= '0;
        end else if (wr_en) begin
            shadow_q[int'(wr_idx)*WORD_W +: WORD_W] <= wr_data;
        end
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            lut_mask <= '0;
        end else if (commit) begin
            lut_mask <= shadow_q;
        end
    end

endmodule

// File: rtl/clb_cfg_loader.sv
// Framed config loader feeding the cluster LUT masks with XOR-checksum gated atomic commit.
// Optional readback port enabled by defining CLB_CFG_READBACK_EN.
//
// state  | meaning
// IDLE   | waiting for cfg_start, not accepting words
// LOAD   | accepting mask words into the shadow, folding them into the checksum
// CHECK  | accepting the checksum word and comparing it
// COMMIT | copying shadow to the active masks, pulsing cfg_done
module clb_cfg_loader
    import clb_cfg_pkg::*;
#(
    parameter int  NUM_LUTS = 10,
    parameter int  MASK_W   = 64,
    parameter int  WORD_W   = 16,
    localparam int NWORDS   = calc_frame_words(NUM_LUTS, MASK_W, WORD_W),
    localparam int CNT_W    = $clog2(NWORDS + 1),
    localparam int RB_W     = $clog2(NWORDS)
) (
    input  logic                       C,
    input  logic                       R,
    clb_cfg_if.slave                   cfg,
    output logic [NUM_LUTS*MASK_W-1:0] lut_mask
`ifdef CLB_CFG_READBACK_EN
    ,
    input  logic [RB_W-1:0]            rb_addr,
    output logic [WORD_W-1:0]          rb_data
`endif
);

    cfg_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] csum_q, csum_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              wr_en, commit, accept, in_frame;

    assign in_frame      = (state_q == LOAD) || (state_q == CHECK);
    assign accept        = cfg.cfg_valid && in_frame;
    assign cfg.cfg_ready = in_frame;
    assign cfg.cfg_busy  = in_frame;
    assign cfg.cfg_done  = done_q;
    assign cfg.cfg_err   = err_q;

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            csum_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg.cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    csum_d  = '0;
                end
            end
            LOAD: begin
                // A restart wins over a word presented on the same cycle.
                if (cfg.cfg_start) begin
                    cnt_d  = '0;
                    csum_d = '0;
                end else if (accept) begin
                    wr_en  = 1'b1;
                    csum_d = csum_q ^ cfg.cfg_data;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NWORDS - 1)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (cfg.cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    csum_d  = '0;
                end else if (accept) begin
                    if (cfg.cfg_data == csum_q) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    clb_cfg_shadow #(
        .NUM_LUTS (NUM_LUTS),
        .MASK_W   (MASK_W),
        .WORD_W   (WORD_W),
        .IDX_W    (CNT_W)
    ) u_shadow (
        .C        (C),
        .R        (R),
        .wr_en    (wr_en),
        .wr_idx   (cnt_q),
        .wr_data  (cfg.cfg_data),
        .commit   (commit),
        .lut_mask (lut_mask)
    );

`ifdef CLB_CFG_READBACK_EN
    logic [WORD_W-1:0] rb_data_q;

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            rb_data_q <= '0;
        end else if (int'(rb_addr) < NWORDS) begin
            rb_data_q <= lut_mask[int'(rb_addr)*WORD_W +: WORD_W];
        end else begin
            rb_data_q <= '0;
        end
    end

    assign rb_data = rb_data_q;
`endif

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed self-checking bench for clb_cfg_loader; readback steps run when CLB_CFG_READBACK_EN is defined.
module tb_clb_cfg_loader;

    localparam int NUM_LUTS = 10;
    localparam int MASK_W   = 64;
    localparam int WORD_W   = 16;
    localparam int NWORDS   = 40;

    logic                       C;
    logic                       R;
    logic [NUM_LUTS*MASK_W-1:0] lut_mask;
    int                         n_checks;
    int                         n_fail;

    clb_cfg_if #(.WORD_W(WORD_W)) cfg_if ();

`ifdef CLB_CFG_READBACK_EN
    logic [5:0]        rb_addr;
    logic [WORD_W-1:0] rb_data;
`endif

    clb_cfg_loader #(
        .NUM_LUTS (NUM_LUTS),
        .MASK_W   (MASK_W),
        .WORD_W   (WORD_W)
    ) dut (
        .C        (C),
        .R        (R),
        .cfg      (cfg_if),
        .lut_mask (lut_mask)
`ifdef CLB_CFG_READBACK_EN
        ,
        .rb_addr  (rb_addr),
        .rb_data  (rb_data)
`endif
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame whose word n (0-based) is base+n+1.
    function automatic logic [639:0] mask_of(input logic [15:0] base);
        logic [639:0] m;
        m = '0;
        for (int i = 0; i < NWORDS; i++) m[i*16 +: 16] = base + 16'(i + 1);
        return m;
    endfunction

    task automatic send_word(input string tag, input logic [15:0] w, input int drop_pct);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            cfg_if.cfg_valid = ($urandom_range(99) >= drop_pct);
            cfg_if.cfg_data  = w;
            acc = cfg_if.cfg_valid && cfg_if.cfg_ready;
            tick();
            n++;
        end
        cfg_if.cfg_valid = 1'b0;
        check({tag, "_handshake"}, acc, 1'b1);
    endtask

    // Returns just after the checksum handshake edge.
    task automatic send_frame(input string tag, input logic [15:0] base, input int drop_pct,
                              input bit do_start, input logic [15:0] csum_flip);
        logic [15:0] csum;
        csum = '0;
        if (do_start) begin
            cfg_if.cfg_start = 1'b1;
            tick();
            cfg_if.cfg_start = 1'b0;
        end
        check({tag, "_busy_load"}, cfg_if.cfg_busy, 1'b1);
        for (int i = 0; i < NWORDS; i++) begin
            csum ^= base + 16'(i + 1);
            send_word(tag, base + 16'(i + 1), drop_pct);
        end
        check({tag, "_busy_check"}, cfg_if.cfg_busy, 1'b1);
        send_word(tag, csum ^ csum_flip, drop_pct);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        R = 1'b0;
        cfg_if.cfg_start = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = '0;
`ifdef CLB_CFG_READBACK_EN
        rb_addr = '0;
`endif
        repeat (3) tick();
        check("rst_mask", lut_mask, '0);
        check("rst_busy", cfg_if.cfg_busy, 1'b0);
        check("rst_ready", cfg_if.cfg_ready, 1'b0);
        check("rst_done", cfg_if.cfg_done, 1'b0);
        check("rst_err", cfg_if.cfg_err, 1'b0);
`ifdef CLB_CFG_READBACK_EN
        check("rst_rb", rb_data, 16'h0000);
`endif
        R = 1'b1;
        tick();

        // Reset asserted in the middle of a frame.
        cfg_if.cfg_start = 1'b1;
        tick();
        cfg_if.cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) send_word("midrst", 16'h55A0 + 16'(i), 0);
        #2 R = 1'b0;
        #1;
        check("midrst_busy", cfg_if.cfg_busy, 1'b0);
        check("midrst_ready", cfg_if.cfg_ready, 1'b0);
        check("midrst_mask", lut_mask, '0);
        R = 1'b1;
        tick();
        check("midrst_idle", cfg_if.cfg_busy, 1'b0);

        // Full frame 0x0001..0x0028 with correct checksum.
        send_frame("frameA", 16'h0000, 0, 1'b1, 16'h0000);
        check("frameA_mask_before", lut_mask, '0);
        check("frameA_done_before", cfg_if.cfg_done, 1'b0);
        tick();
        check("frameA_done", cfg_if.cfg_done, 1'b1);
        check("frameA_mask", lut_mask, mask_of(16'h0000));
        check("frameA_lut0", lut_mask[63:0], 64'h0004_0003_0002_0001);
        check("frameA_lut9", lut_mask[639:576], 64'h0028_0027_0026_0025);
        check("frameA_busy", cfg_if.cfg_busy, 1'b0);
        tick();
        check("frameA_done_once", cfg_if.cfg_done, 1'b0);

        // Bad checksum leaves the active masks alone.
        send_frame("badck", 16'h0100, 0, 1'b1, 16'h0001);
        check("badck_err", cfg_if.cfg_err, 1'b1);
        check("badck_busy", cfg_if.cfg_busy, 1'b0);
        check("badck_done", cfg_if.cfg_done, 1'b0);
        tick();
        check("badck_err_once", cfg_if.cfg_err, 1'b0);
        check("badck_done_after", cfg_if.cfg_done, 1'b0);
        check("badck_mask", lut_mask, mask_of(16'h0000));

        // Words offered while idle are ignored.
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = 16'h1234;
        repeat (3) tick();
        cfg_if.cfg_valid = 1'b0;
        check("idle_drop_busy", cfg_if.cfg_busy, 1'b0);
        check("idle_drop_mask", lut_mask, mask_of(16'h0000));

        // Restart after 17 words; the word beside the restart pulse is dropped.
        cfg_if.cfg_start = 1'b1;
        tick();
        cfg_if.cfg_start = 1'b0;
        for (int i = 0; i < 17; i++) send_word("restart_pre", 16'h0E00 + 16'(i), 0);
        cfg_if.cfg_start = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = 16'hBEEF;
        tick();
        cfg_if.cfg_start = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        send_frame("restart", 16'h0300, 0, 1'b0, 16'h0000);
        tick();
        check("restart_done", cfg_if.cfg_done, 1'b1);
        check("restart_err", cfg_if.cfg_err, 1'b0);
        check("restart_mask", lut_mask, mask_of(16'h0300));
        check("restart_lut0", lut_mask[63:0], 64'h0304_0303_0302_0301);

        // Backpressure; a start pulse during COMMIT must be ignored.
        send_frame("bp", 16'h0000, 30, 1'b1, 16'h0000);
        cfg_if.cfg_start = 1'b1;
        tick();
        cfg_if.cfg_start = 1'b0;
        check("bp_done", cfg_if.cfg_done, 1'b1);
        check("bp_mask", lut_mask, mask_of(16'h0000));
        check("bp_lut0", lut_mask[63:0], 64'h0004_0003_0002_0001);
        check("bp_commit_start_ignored", cfg_if.cfg_busy, 1'b0);
        tick();
        check("bp_still_idle", cfg_if.cfg_busy, 1'b0);
        check("bp_done_once", cfg_if.cfg_done, 1'b0);

`ifdef CLB_CFG_READBACK_EN
        rb_addr = 6'd5;
        tick();
        check("rb_addr5", rb_data, 16'h0006);
        rb_addr = 6'd39;
        tick();
        check("rb_addr39", rb_data, 16'h0028);
        rb_addr = 6'd45;
        tick();
        check("rb_out_of_range", rb_data, 16'h0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
